// File: rtl/tile_axi_isolate_ctrl.sv
// AXI AW/AR gate for the tile narrow port: caps outstanding writes/reads and
// quiesces the port (block, drain, report isolated) ahead of tile reset or clock gating.
module tile_axi_isolate_ctrl #(
    parameter int unsigned MaxOutstanding = 16,
    parameter int unsigned CntWidth       = $clog2(MaxOutstanding + 1)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                isolate_i,
    output logic                isolated_o,
    input  logic                slv_aw_valid_i,
    output logic                slv_aw_ready_o,
    output logic                mst_aw_valid_o,
    input  logic                mst_aw_ready_i,
    input  logic                slv_ar_valid_i,
    output logic                slv_ar_ready_o,
    output logic                mst_ar_valid_o,
    input  logic                mst_ar_ready_i,
    input  logic                b_hs_i,
    input  logic                r_last_hs_i,
    output logic [CntWidth-1:0] wr_cnt_o,
    output logic [CntWidth-1:0] rd_cnt_o,
    output logic                err_o
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        DRAIN    = 2'd1,
        ISOLATED = 2'd2
    } state_e;

    localparam logic [CntWidth-1:0] MaxCnt = CntWidth'(MaxOutstanding);
    localparam logic [CntWidth-1:0] One    = CntWidth'(1);

    state_e              state_q;
    logic                isolated_q;
    logic                err_q;
    logic                aw_pending_q, aw_pending_d;
    logic                ar_pending_q, ar_pending_d;
    logic [CntWidth-1:0] wr_cnt_q, wr_cnt_d;
    logic [CntWidth-1:0] rd_cnt_q, rd_cnt_d;
    logic                aw_open, ar_open;
    logic                aw_hs, ar_hs;
    logic                wr_err, rd_err;
    logic                drained;

    // A request already shown to the NI stays open regardless of state or fill level.
    assign aw_open = aw_pending_q | ((state_q == RUN) && (wr_cnt_q < MaxCnt));
    assign ar_open = ar_pending_q | ((state_q == RUN) && (rd_cnt_q < MaxCnt));

    assign mst_aw_valid_o = slv_aw_valid_i & aw_open;
    assign slv_aw_ready_o = mst_aw_ready_i & aw_open;
    assign mst_ar_valid_o = slv_ar_valid_i & ar_open;
    assign slv_ar_ready_o = mst_ar_ready_i & ar_open;

    assign aw_hs = mst_aw_valid_o & mst_aw_ready_i;
    assign ar_hs = mst_ar_valid_o & mst_ar_ready_i;

    always_comb begin
        wr_cnt_d = wr_cnt_q;
        wr_err   = 1'b0;
        if (aw_hs && !b_hs_i) begin
            wr_cnt_d = wr_cnt_q + One;
        end else if (!aw_hs && b_hs_i) begin
            if (wr_cnt_q == '0) wr_err = 1'b1;
            else                wr_cnt_d = wr_cnt_q - One;
        end
    end

    always_comb begin
        rd_cnt_d = rd_cnt_q;
        rd_err   = 1'b0;
        if (ar_hs && !r_last_hs_i) begin
            rd_cnt_d = rd_cnt_q + One;
        end else if (!ar_hs && r_last_hs_i) begin
            if (rd_cnt_q == '0) rd_err = 1'b1;
            else                rd_cnt_d = rd_cnt_q - One;
        end
    end

    always_comb begin
        aw_pending_d = aw_pending_q;
        if (aw_hs)               aw_pending_d = 1'b0;
        else if (mst_aw_valid_o) aw_pending_d = 1'b1;
        ar_pending_d = ar_pending_q;
        if (ar_hs)               ar_pending_d = 1'b0;
        else if (mst_ar_valid_o) ar_pending_d = 1'b1;
    end

    // Judged on next-state values so the final completion cycle moves straight to ISOLATED.
    assign drained = (wr_cnt_d == '0) && (rd_cnt_d == '0) && !aw_pending_d && !ar_pending_d;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= RUN;
            isolated_q   <= 1'b0;
            err_q        <= 1'b0;
            aw_pending_q <= 1'b0;
            ar_pending_q <= 1'b0;
            wr_cnt_q     <= '0;
            rd_cnt_q     <= '0;
        end else begin
            wr_cnt_q     <= wr_cnt_d;
            rd_cnt_q     <= rd_cnt_d;
            aw_pending_q <= aw_pending_d;
            ar_pending_q <= ar_pending_d;
            err_q        <= err_q | wr_err | rd_err;
            case (state_q)
                RUN: begin
                    if (isolate_i) state_q <= DRAIN;
                end
                DRAIN: begin
                    if (!isolate_i) begin
                        state_q <= RUN;
                    end else if (drained) begin
                        state_q    <= ISOLATED;
                        isolated_q <= 1'b1;
                    end
                end
                ISOLATED: begin
                    if (!isolate_i) begin
                        state_q    <= RUN;
                        isolated_q <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= RUN;
                    isolated_q <= 1'b0;
                end
            endcase
        end
    end

    assign isolated_o = isolated_q;
    assign wr_cnt_o   = wr_cnt_q;
    assign rd_cnt_o   = rd_cnt_q;
    assign err_o      = err_q;

endmodule

// File: tb/tb_tile_axi_isolate_ctrl.sv
// Scoreboard bench: stimulus queues expected forwarded handshakes and status values;
// a negedge monitor pops and compares them against what the DUTs present.
module tb_tile_axi_isolate_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    // DUT A: MaxOutstanding=16
    logic rst_n = 1'b0, iso = 1'b0, aw_v = 1'b0, aw_r = 1'b0, ar_v = 1'b0, ar_r = 1'b0;
    logic b_hs = 1'b0, r_hs = 1'b0;
    logic isolated, s_aw_rdy, m_aw_vld, s_ar_rdy, m_ar_vld, err;
    logic [4:0] wr_cnt, rd_cnt;

    // DUT B: MaxOutstanding=2
    logic b_iso = 1'b0, b_aw_v = 1'b0, b_aw_r = 1'b0, b_ar_v = 1'b0, b_ar_r = 1'b0;
    logic b_b_hs = 1'b0, b_r_hs = 1'b0;
    logic b_isolated, b_s_aw_rdy, b_m_aw_vld, b_s_ar_rdy, b_m_ar_vld, b_err;
    logic [1:0] b_wr_cnt, b_rd_cnt;

    tile_axi_isolate_ctrl #(.MaxOutstanding(16)) dut (
        .clk_i(clk), .rst_ni(rst_n), .isolate_i(iso), .isolated_o(isolated),
        .slv_aw_valid_i(aw_v), .slv_aw_ready_o(s_aw_rdy), .mst_aw_valid_o(m_aw_vld), .mst_aw_ready_i(aw_r),
        .slv_ar_valid_i(ar_v), .slv_ar_ready_o(s_ar_rdy), .mst_ar_valid_o(m_ar_vld), .mst_ar_ready_i(ar_r),
        .b_hs_i(b_hs), .r_last_hs_i(r_hs), .wr_cnt_o(wr_cnt), .rd_cnt_o(rd_cnt), .err_o(err)
    );

    tile_axi_isolate_ctrl #(.MaxOutstanding(2)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .isolate_i(b_iso), .isolated_o(b_isolated),
        .slv_aw_valid_i(b_aw_v), .slv_aw_ready_o(b_s_aw_rdy), .mst_aw_valid_o(b_m_aw_vld), .mst_aw_ready_i(b_aw_r),
        .slv_ar_valid_i(b_ar_v), .slv_ar_ready_o(b_s_ar_rdy), .mst_ar_valid_o(b_m_ar_vld), .mst_ar_ready_i(b_ar_r),
        .b_hs_i(b_b_hs), .r_last_hs_i(b_r_hs), .wr_cnt_o(b_wr_cnt), .rd_cnt_o(b_rd_cnt), .err_o(b_err)
    );

    localparam int S_WR = 0, S_RD = 1, S_ISO = 2, S_ERR = 3, S_MAWV = 4, S_MARV = 5, S_SAWR = 6, S_SARR = 7;

    typedef struct {
        int    dsel;
        int    id;
        int    val;
        string name;
    } chk_t;

    chk_t chk_q[$];
    int   aw_q[$];   // expected cycles of forwarded AW handshakes, DUT A
    int   ar_q[$];   // expected cycles of forwarded AR handshakes, DUT A
    int   bar_q[$];  // expected cycles of forwarded AR handshakes, DUT B

    function automatic int get_sig(int dsel, int id);
        if (dsel == 0) begin
            case (id)
                S_WR:   return int'(wr_cnt);
                S_RD:   return int'(rd_cnt);
                S_ISO:  return int'(isolated);
                S_ERR:  return int'(err);
                S_MAWV: return int'(m_aw_vld);
                S_MARV: return int'(m_ar_vld);
                S_SAWR: return int'(s_aw_rdy);
                default: return int'(s_ar_rdy);
            endcase
        end else begin
            case (id)
                S_WR:   return int'(b_wr_cnt);
                S_RD:   return int'(b_rd_cnt);
                S_ISO:  return int'(b_isolated);
                S_ERR:  return int'(b_err);
                S_MAWV: return int'(b_m_aw_vld);
                S_MARV: return int'(b_m_ar_vld);
                S_SAWR: return int'(b_s_aw_rdy);
                default: return int'(b_s_ar_rdy);
            endcase
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input int dsel, input int id, input int val, input string name);
        chk_t c;
        c.dsel = dsel; c.id = id; c.val = val; c.name = name;
        chk_q.push_back(c);
    endtask

    task automatic hs_pop(inout int q[$], input string name);
        total++;
        if (q.size() == 0) begin
            bad++;
            $display("FAIL %s: unexpected forwarded handshake at cycle %0d, none required", name, cyc);
        end else begin
            int e;
            e = q.pop_front();
            if (e != cyc) begin
                bad++;
                $display("FAIL %s: handshake at cycle %0d, required at cycle %0d", name, cyc, e);
            end
        end
    endtask

    // Monitor: samples mid-cycle, away from the posedge where inputs change.
    always @(negedge clk) begin
        if (rst_n) begin
            if (m_aw_vld && aw_r)     hs_pop(aw_q,  "aw_fwd");
            if (m_ar_vld && ar_r)     hs_pop(ar_q,  "ar_fwd");
            if (b_m_ar_vld && b_ar_r) hs_pop(bar_q, "b_ar_fwd");
        end
        while (chk_q.size() > 0) begin
            chk_t c;
            int   a;
            c = chk_q.pop_front();
            a = get_sig(c.dsel, c.id);
            total++;
            if (a != c.val) begin
                bad++;
                $display("FAIL %s: cycle %0d actual=%0d required=%0d", c.name, cyc, a, c.val);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, actual=timeout required=finish");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        // reset
        step(); step();
        chk(0, S_WR, 0, "rst_wr"); chk(0, S_RD, 0, "rst_rd");
        chk(0, S_ISO, 0, "rst_iso"); chk(0, S_ERR, 0, "rst_err");
        rst_n = 1'b1;
        step();

        // 3 AW forwarded, then 3 B completions
        aw_v = 1; aw_r = 1;
        for (int i = 0; i < 3; i++) begin
            aw_q.push_back(cyc);
            chk(0, S_WR, i, "t1_wr_inc");
            step();
        end
        aw_v = 0; aw_r = 0;
        b_hs = 1;
        for (int i = 3; i > 0; i--) begin
            chk(0, S_WR, i, "t1_wr_dec");
            step();
        end
        b_hs = 0;
        chk(0, S_WR, 0, "t1_wr_zero"); chk(0, S_ERR, 0, "t1_err");
        step();

        // DUT B: limit of 2 outstanding reads
        b_ar_v = 1; b_ar_r = 1;
        bar_q.push_back(cyc); chk(1, S_RD, 0, "t2_rd0");
        step();
        bar_q.push_back(cyc); chk(1, S_RD, 1, "t2_rd1");
        step();
        chk(1, S_RD, 2, "t2_rd_full"); chk(1, S_MARV, 0, "t2_blocked_v"); chk(1, S_SARR, 0, "t2_blocked_r");
        b_r_hs = 1;
        step();
        b_r_hs = 0;
        bar_q.push_back(cyc); chk(1, S_RD, 1, "t2_rd_after_r"); chk(1, S_MARV, 1, "t2_third_fwd");
        step();
        b_ar_v = 0; b_ar_r = 0;
        chk(1, S_RD, 2, "t2_rd_final");
        step();

        // AW held during isolate request
        aw_v = 1; aw_r = 1; aw_q.push_back(cyc);
        step();
        aw_r = 0; iso = 1;
        chk(0, S_WR, 1, "t3_wr1"); chk(0, S_MAWV, 1, "t3_valid_run");
        step();
        chk(0, S_MAWV, 1, "t3_valid_drain"); chk(0, S_SAWR, 0, "t3_ready_drain"); chk(0, S_ISO, 0, "t3_iso0");
        step();
        aw_r = 1; aw_q.push_back(cyc); chk(0, S_MAWV, 1, "t3_valid_accept");
        step();
        aw_v = 0; aw_r = 0; b_hs = 1;
        chk(0, S_WR, 2, "t3_wr2"); chk(0, S_ISO, 0, "t3_iso_wait2");
        step();
        chk(0, S_WR, 1, "t3_wr_b1"); chk(0, S_ISO, 0, "t3_iso_wait1");
        step();
        b_hs = 0;
        chk(0, S_ISO, 1, "t3_iso_up"); chk(0, S_WR, 0, "t3_wr_drained");
        iso = 0;
        step();
        chk(0, S_ISO, 0, "t3_iso_down");
        step();

        // idle port isolation, AR held while isolated
        iso = 1; chk(0, S_ISO, 0, "t4_iso_t0");
        step();
        ar_v = 1; ar_r = 1;
        chk(0, S_MARV, 0, "t4_drain_block"); chk(0, S_ISO, 0, "t4_iso_t1");
        step();
        chk(0, S_ISO, 1, "t4_iso_t2"); chk(0, S_MARV, 0, "t4_iso_block_v"); chk(0, S_SARR, 0, "t4_iso_block_r");
        step();
        chk(0, S_ISO, 1, "t4_iso_hold"); chk(0, S_MARV, 0, "t4_iso_hold_v");
        iso = 0;
        step();
        ar_q.push_back(cyc); chk(0, S_ISO, 0, "t4_iso_fall");
        step();
        ar_v = 0; ar_r = 0; chk(0, S_RD, 1, "t4_rd1");
        r_hs = 1;
        step();
        r_hs = 0; chk(0, S_RD, 0, "t4_rd0");
        step();

        // abort drain with a read outstanding
        ar_v = 1; ar_r = 1; ar_q.push_back(cyc);
        step();
        ar_v = 0; ar_r = 0; iso = 1; chk(0, S_RD, 1, "t5_rd1");
        step();
        ar_v = 1; ar_r = 1; iso = 0;
        chk(0, S_MARV, 0, "t5_drain_block"); chk(0, S_ISO, 0, "t5_iso_drain");
        step();
        ar_q.push_back(cyc); chk(0, S_ISO, 0, "t5_iso_run"); chk(0, S_MARV, 1, "t5_new_ar");
        step();
        ar_v = 0; ar_r = 0; chk(0, S_RD, 2, "t5_rd2"); chk(0, S_ISO, 0, "t5_iso_never");
        r_hs = 1;
        step(); step();
        r_hs = 0; chk(0, S_RD, 0, "t5_rd0");
        step();

        // completion at zero count, then reset mid-drain
        b_hs = 1; chk(0, S_ERR, 0, "t6_err_before");
        step();
        b_hs = 0; chk(0, S_ERR, 1, "t6_err_set"); chk(0, S_WR, 0, "t6_wr_stays0");
        step();
        aw_v = 1; aw_r = 1; aw_q.push_back(cyc); chk(0, S_ERR, 1, "t6_err_sticky");
        step();
        aw_v = 0; aw_r = 0; iso = 1; chk(0, S_WR, 1, "t6_wr1");
        step();
        rst_n = 0; iso = 0;
        step();
        chk(0, S_WR, 0, "t6_rst_wr"); chk(0, S_RD, 0, "t6_rst_rd");
        chk(0, S_ISO, 0, "t6_rst_iso"); chk(0, S_ERR, 0, "t6_rst_err");
        rst_n = 1;
        step();
        aw_v = 1; aw_r = 1; aw_q.push_back(cyc); chk(0, S_MAWV, 1, "t6_run_after_rst");
        step();
        aw_v = 0; aw_r = 0; chk(0, S_WR, 1, "t6_wr_after_rst");
        step();

        @(negedge clk); @(negedge clk);
        #1;
        total++; if (aw_q.size()  != 0) begin bad++; $display("FAIL aw_left: actual=%0d required=0", aw_q.size());  end
        total++; if (ar_q.size()  != 0) begin bad++; $display("FAIL ar_left: actual=%0d required=0", ar_q.size());  end
        total++; if (bar_q.size() != 0) begin bad++; $display("FAIL b_ar_left: actual=%0d required=0", bar_q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
